button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 83 ++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: three-channel push-button front end.
// Every raw button is synchronised and debounced independently. The btn_a and
// btn_b channels are exposed as levels. The btn_ena channel drives a level that
// toggles on each debounced press, and a one-cycle press strobe.
module button_conditioner #(
    parameter int DEB_CYCLES = 12000,
    parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
    input  logic clk,
    input  logic rst_reg,
    input  logic btn_a,
    input  logic btn_b,
    input  logic btn_ena,
    output logic a,
    output logic b,
    output logic ena,
    output logic ena_pulse
);

    localparam int unsigned NCH = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [NCH-1:0] raw;
    logic           ena_rise;

    // Gather the raw buttons so every channel gets identical conditioning.
    always_comb begin
        raw = {btn_ena, btn_b, btn_a};
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic             stable;
        logic [CNT_W-1:0] cnt;

        // Two-flop synchroniser, then commit sync2 to stable after DEB_CYCLES disagreeing samples.
        always_ff @(posedge clk or posedge rst_reg) begin
            if (rst_reg) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                stable <= 1'b0;
                cnt    <= '0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                if (sync2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // A press is the edge on which the enable channel's stable register commits 0->1.
    always_comb begin
        ena_rise = ~g_ch[2].stable & g_ch[2].sync2 & (g_ch[2].cnt == CNT_MAX);
    end

    // Data outputs are the debounced levels themselves.
    always_comb begin
        a = g_ch[0].stable;
        b = g_ch[1].stable;
    end

    // Toggle the enable level and strobe once, on the same edge the press commits.
    always_ff @(posedge clk or posedge rst_reg) begin
        if (rst_reg) begin
            ena       <= 1'b0;
            ena_pulse <= 1'b0;
        end else begin
            ena_pulse <= ena_rise;
            if (ena_rise) begin
                ena <= ~ena;
            end
        end
    end

endmodule
